// File: rtl/dso_pkg.sv
// Shared constants, frame-length helper and capture FSM states for the DSO trigger path.
package dso_pkg;

  localparam int ADDR_W           = 9;
  localparam int DATA_W           = 8;
  localparam int FRAME_LEN_SINGLE = 200;
  localparam int FRAME_LEN_DOUBLE = 400;

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    WAIT_TRIG,
    POST,
    DONE
  } cap_state_e;

  function automatic logic [ADDR_W-1:0] frame_len(input logic double_sel);
    return double_sel ? ADDR_W'(FRAME_LEN_DOUBLE) : ADDR_W'(FRAME_LEN_SINGLE);
  endfunction

endpackage

// File: rtl/trig_detect.sv
// Edge/level trigger comparator: remembers the previously stored sample and
// raises a single-cycle hit when the new sample crosses the level on the chosen edge.
module trig_detect
  import dso_pkg::*;
(
  input  logic              sys_clk,
  input  logic              rst_n,
  input  logic              sample_valid,
  input  logic              eval_en,
  input  logic [DATA_W-1:0] sample,
  input  logic [DATA_W-1:0] level,
  input  logic              slope,
  output logic              hit
);

  logic [DATA_W-1:0] prev_q;
  logic [DATA_W-1:0] prev_d;
  logic              rise;
  logic              fall;

  always_comb begin
    prev_d = prev_q;
    if (sample_valid) begin
      prev_d = sample;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      prev_q <= '0;
    end else begin
      prev_q <= prev_d;
    end
  end

  // Level and slope are used live so a change applies to the very next strobe.
  always_comb begin
    rise = (prev_q < level) && (sample >= level);
    fall = (prev_q > level) && (sample <= level);
    hit  = sample_valid && eval_en && (slope ? rise : fall);
  end

endmodule

// File: rtl/trigger_capture.sv
// Pre/post-trigger frame capture into a circular RAM of 200 or 400 samples.
// Define TRIG_AUTO_EN to build the auto-trigger timeout counter.
module trigger_capture
  import dso_pkg::*;
#(
  parameter int PRETRIG      = 32,
  parameter int AUTO_TIMEOUT = 1000
) (
  input  logic              sys_clk,
  input  logic              rst_n,
  input  logic              sample_en,
  input  logic [DATA_W-1:0] adc_db,
  input  logic              sample_type,
  input  logic [DATA_W-1:0] trig_level,
  input  logic              trig_slope,
  input  logic              arm,
  input  logic              frame_ack,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic [ADDR_W-1:0] trig_addr,
  output logic              busy,
  output logic              frame_done,
  output logic              auto_trig
);

  localparam logic [ADDR_W-1:0] PRE_LAST = ADDR_W'(PRETRIG - 1);

  cap_state_e        state_q, state_d;
  logic              len_sel_q, len_sel_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic [ADDR_W-1:0] trig_addr_q, trig_addr_d;

  logic              capturing;
  logic              strobe;
  logic              hit;
  logic              auto_fire;
  logic              trig_event;
  logic [ADDR_W-1:0] len_w;
  logic [ADDR_W-1:0] post_last;
  logic [ADDR_W-1:0] ptr_next;

  always_comb begin
    capturing  = (state_q == PRE) || (state_q == WAIT_TRIG) || (state_q == POST);
    strobe     = sample_en && capturing;
    trig_event = hit || auto_fire;
    len_w      = frame_len(len_sel_q);
    post_last  = len_w - ADDR_W'(PRETRIG + 2);
    ptr_next   = (ptr_q == len_w - ADDR_W'(1)) ? '0 : ptr_q + ADDR_W'(1);
  end

  trig_detect u_trig_detect (
    .sys_clk      (sys_clk),
    .rst_n        (rst_n),
    .sample_valid (strobe),
    .eval_en      (state_q == WAIT_TRIG),
    .sample       (adc_db),
    .level        (trig_level),
    .slope        (trig_slope),
    .hit          (hit)
  );

`ifdef TRIG_AUTO_EN
  localparam int AUTO_W = $clog2(AUTO_TIMEOUT + 1);

  logic [AUTO_W-1:0] auto_cnt_q, auto_cnt_d;
  logic              auto_trig_q, auto_trig_d;

  // A real crossing on the timeout strobe wins, so auto_trig stays clear then.
  always_comb begin
    auto_cnt_d  = auto_cnt_q;
    auto_trig_d = auto_trig_q;
    auto_fire   = strobe && (state_q == WAIT_TRIG) && !hit &&
                  (auto_cnt_q == AUTO_W'(AUTO_TIMEOUT - 1));
    if (state_q != WAIT_TRIG) begin
      auto_cnt_d = '0;
    end else if (strobe) begin
      auto_cnt_d = auto_cnt_q + AUTO_W'(1);
    end
    if (hit || auto_fire) begin
      auto_trig_d = auto_fire;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      auto_cnt_q  <= '0;
      auto_trig_q <= 1'b0;
    end else begin
      auto_cnt_q  <= auto_cnt_d;
      auto_trig_q <= auto_trig_d;
    end
  end

  assign auto_trig = auto_trig_q;
`else
  assign auto_fire = 1'b0;
  assign auto_trig = 1'b0;
`endif

  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (arm) state_d = PRE;
      PRE:       if (strobe && (cnt_q == PRE_LAST)) state_d = WAIT_TRIG;
      WAIT_TRIG: if (trig_event) state_d = POST;
      POST:      if (strobe && (cnt_q == post_last)) state_d = DONE;
      DONE:      if (frame_ack) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    busy       = 1'b0;
    frame_done = 1'b0;
    case (state_q)
      PRE, WAIT_TRIG, POST: busy       = 1'b1;
      DONE:                 frame_done = 1'b1;
      default:              ;
    endcase
  end

  // Each phase counts only its own writes; the counter restarts on every state change.
  always_comb begin
    len_sel_d   = len_sel_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    trig_addr_d = trig_addr_q;
    if ((state_q == IDLE) && arm) begin
      len_sel_d = sample_type;
      ptr_d     = '0;
      cnt_d     = '0;
    end
    if (strobe) begin
      wr_en_d   = 1'b1;
      wr_addr_d = ptr_q;
      wr_data_d = adc_db;
      ptr_d     = ptr_next;
      if (state_q != WAIT_TRIG) begin
        cnt_d = cnt_q + ADDR_W'(1);
      end
    end
    if (state_d != state_q) begin
      cnt_d = '0;
    end
    if (trig_event) begin
      trig_addr_d = ptr_q;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      len_sel_q   <= 1'b0;
      ptr_q       <= '0;
      cnt_q       <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      trig_addr_q <= '0;
    end else begin
      len_sel_q   <= len_sel_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      trig_addr_q <= trig_addr_d;
    end
  end

  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign trig_addr = trig_addr_q;

endmodule
